optic_flow_color_seq: RTL and testbench

- Multi-cycle custom-instruction block that batch-converts packed optic-flow direction nibbles into RGB565 pixel pairs for the display path.
- The CPU pushes 32-bit words of 8 flow nibbles into a 4-entry input FIFO.
- An internal sequencer expands each word over 4 beats into 4 RGB565-pair words and writes them to an 8-entry output FIFO.
- The CPU pops the colour words. It sits on the CPU custom-instruction bus next to the other optic-flow CIs.

---
 rtl/optic_flow_color_seq.sv | 167 ++++++++++++++++
 tb/tb_optic_flow_color_seq.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/optic_flow_color_seq.sv
// Optic-flow nibble to RGB565 custom instruction: 4-entry word input FIFO,
// 4-beat expansion sequencer and 8-entry colour-pair output FIFO.
module optic_flow_color_seq #(
    parameter logic [7:0] customInstructionId = 8'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  ciN,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    output logic        done,
    output logic [31:0] result
);

    localparam logic [1:0] OP_PUSH   = 2'd0;
    localparam logic [1:0] OP_POP    = 2'd1;
    localparam logic [1:0] OP_STATUS = 2'd2;
    localparam logic [1:0] OP_CLEAR  = 2'd3;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_CONV = 1'b1;

    // Nibble {up, down, left, right}; a down flag lights every channel.
    function automatic logic [15:0] rgb565(input logic [3:0] nib);
        rgb565 = {nib[1] | nib[2], 4'b0000,
                  nib[0] | nib[2], 5'b00000,
                  nib[3] | nib[2], 4'b0000};
    endfunction

    logic [31:0] in_fifo_r  [4];
    logic [31:0] out_fifo_r [8];
    logic [1:0]  in_rd_ptr_r, in_wr_ptr_r;
    logic [2:0]  in_count_r;
    logic [2:0]  out_rd_ptr_r, out_wr_ptr_r;
    logic [3:0]  out_count_r;
    logic [0:0]  state_r;
    logic [1:0]  beat_r;
    logic        pop_pending_r;

    logic        active_s, push_ok_s, pop_try_s, pop_s, pop_empty_s, clear_s;
    logic        conv_wr_s, conv_deq_s;
    logic [7:0]  beat_byte_s;
    logic [31:0] conv_word_s;
    logic [31:0] status_s;

    // Instruction decode and converter write gating.
    always_comb begin
        active_s    = reset && start && (ciN == customInstructionId) && !pop_pending_r;
        push_ok_s   = active_s && (valueB[1:0] == OP_PUSH) && (in_count_r < 3'd4);
        clear_s     = active_s && (valueB[1:0] == OP_CLEAR);
        pop_try_s   = reset && ((active_s && (valueB[1:0] == OP_POP)) || pop_pending_r);
        pop_s       = pop_try_s && (out_count_r != 4'd0);
        pop_empty_s = pop_try_s && (out_count_r == 4'd0) && (in_count_r == 3'd0)
                      && (state_r == ST_IDLE);
        conv_wr_s   = reset && !clear_s && (state_r == ST_CONV) && (out_count_r < 4'd8);
        conv_deq_s  = conv_wr_s && (beat_r == 2'd3);
        beat_byte_s = in_fifo_r[in_rd_ptr_r][{beat_r, 3'b000} +: 8];
        conv_word_s = {rgb565(beat_byte_s[7:4]), rgb565(beat_byte_s[3:0])};
        status_s    = {22'd0, (state_r == ST_CONV), pop_pending_r, 1'b0,
                       in_count_r, out_count_r};
    end

    // Completion and result; result stays zero unless done is asserted.
    always_comb begin
        done   = 1'b0;
        result = 32'd0;
        if (pop_s) begin
            done   = 1'b1;
            result = out_fifo_r[out_rd_ptr_r];
        end else if (pop_empty_s) begin
            done   = 1'b1;
            result = 32'd0;
        end else if (active_s) begin
            case (valueB[1:0])
                OP_PUSH: begin
                    done   = 1'b1;
                    result = {31'd0, push_ok_s};
                end
                OP_STATUS: begin
                    done   = 1'b1;
                    result = status_s;
                end
                OP_CLEAR: begin
                    done   = 1'b1;
                    result = 32'd0;
                end
                default: begin
                    done   = 1'b0;
                    result = 32'd0;
                end
            endcase
        end else begin
            done   = 1'b0;
            result = 32'd0;
        end
    end

    // FIFO storage; contents are only meaningful below the counts, so no reset.
    always_ff @(posedge clock) begin
        if (push_ok_s) begin
            in_fifo_r[in_wr_ptr_r] <= valueA;
        end
        if (conv_wr_s) begin
            out_fifo_r[out_wr_ptr_r] <= conv_word_s;
        end
    end

    // Pointers, counts, sequencer and pending-pop state.
    always_ff @(posedge clock) begin
        if (!reset || clear_s) begin
            in_rd_ptr_r   <= 2'd0;
            in_wr_ptr_r   <= 2'd0;
            in_count_r    <= 3'd0;
            out_rd_ptr_r  <= 3'd0;
            out_wr_ptr_r  <= 3'd0;
            out_count_r   <= 4'd0;
            state_r       <= ST_IDLE;
            beat_r        <= 2'd0;
            pop_pending_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                in_wr_ptr_r <= in_wr_ptr_r + 2'd1;
            end
            if (conv_deq_s) begin
                in_rd_ptr_r <= in_rd_ptr_r + 2'd1;
            end
            in_count_r <= in_count_r + {2'b00, push_ok_s} - {2'b00, conv_deq_s};

            if (conv_wr_s) begin
                out_wr_ptr_r <= out_wr_ptr_r + 3'd1;
            end
            if (pop_s) begin
                out_rd_ptr_r <= out_rd_ptr_r + 3'd1;
            end
            out_count_r <= out_count_r + {3'b000, conv_wr_s} - {3'b000, pop_s};

            case (state_r)
                ST_IDLE: begin
                    beat_r <= 2'd0;
                    if (in_count_r != 3'd0) begin
                        state_r <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    if (conv_wr_s) begin
                        beat_r <= beat_r + 2'd1;
                        if (beat_r == 2'd3) begin
                            state_r <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    beat_r  <= 2'd0;
                end
            endcase

            if (pop_s || pop_empty_s) begin
                pop_pending_r <= 1'b0;
            end else if (active_s && (valueB[1:0] == OP_POP)) begin
                pop_pending_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_optic_flow_color_seq.sv
// Directed bench for optic_flow_color_seq with hand-computed expected values.
module tb_optic_flow_color_seq;

    logic        clock;
    logic        reset;
    logic        start;
    logic [7:0]  ciN;
    logic [31:0] valueA;
    logic [31:0] valueB;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    logic        got_done;
    logic [31:0] got_result;

    optic_flow_color_seq #(.customInstructionId(8'd0)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .ciN    (ciN),
        .valueA (valueA),
        .valueB (valueB),
        .done   (done),
        .result (result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Sample outputs on the falling edge, then advance past the next rising edge.
    task automatic sample();
        @(negedge clock);
        got_done   = done;
        got_result = result;
        @(posedge clock);
        #1;
    endtask

    task automatic ci(input logic [7:0] sel, input logic [1:0] op, input logic [31:0] a);
        start  = 1'b1;
        ciN    = sel;
        valueA = a;
        valueB = {30'd0, op};
        sample();
        start  = 1'b0;
        valueA = 32'd0;
        valueB = 32'd0;
        ciN    = 8'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; ciN = 8'd0; valueA = 32'd0; valueB = 32'd0;
        @(posedge clock); #1;
        sample();
        chk("reset_done", {31'd0, got_done}, 32'd0);
        chk("reset_result", got_result, 32'd0);
        reset = 1'b1;

        ci(8'd0, 2'd2, 32'd0);
        chk("status_after_reset_done", {31'd0, got_done}, 32'd1);
        chk("status_after_reset", got_result, 32'h0000_0000);

        ci(8'd1, 2'd2, 32'd0);
        chk("cin_mismatch_done", {31'd0, got_done}, 32'd0);

        // Basic conversion of one word.
        ci(8'd0, 2'd0, 32'h0000_4321);
        chk("push1_done", {31'd0, got_done}, 32'd1);
        chk("push1_result", got_result, 32'd1);
        idle(6);
        ci(8'd0, 2'd1, 32'd0);
        chk("pop0_done", {31'd0, got_done}, 32'd1);
        chk("pop0", got_result, 32'h8000_0400);
        ci(8'd0, 2'd1, 32'd0);
        chk("pop1_done", {31'd0, got_done}, 32'd1);
        chk("pop1", got_result, 32'h8410_8400);
        ci(8'd0, 2'd1, 32'd0);
        chk("pop2_done", {31'd0, got_done}, 32'd1);
        chk("pop2", got_result, 32'h0000_0000);
        ci(8'd0, 2'd1, 32'd0);
        chk("pop3_done", {31'd0, got_done}, 32'd1);
        chk("pop3", got_result, 32'h0000_0000);

        ci(8'd0, 2'd1, 32'd0);
        chk("empty_pop_done", {31'd0, got_done}, 32'd1);
        chk("empty_pop", got_result, 32'd0);

        // Pending POP completes two cycles after issue.
        ci(8'd0, 2'd0, 32'h0000_0088);
        ci(8'd0, 2'd1, 32'd0);
        chk("pending_pop_issue_done", {31'd0, got_done}, 32'd0);
        ci(8'd0, 2'd2, 32'd0);
        chk("start_while_pending_done", {31'd0, got_done}, 32'd0);
        sample();
        chk("pending_pop_done", {31'd0, got_done}, 32'd1);
        chk("pending_pop", got_result, 32'h0010_0010);
        idle(4);
        ci(8'd0, 2'd3, 32'd0);
        chk("clear1_done", {31'd0, got_done}, 32'd1);
        chk("clear1", got_result, 32'd0);

        // Fill out FIFO to 8 and stall the converter.
        ci(8'd0, 2'd0, 32'h0000_4321);
        ci(8'd0, 2'd0, 32'h1111_1111);
        idle(12);
        ci(8'd0, 2'd0, 32'hAAAA_AAAA);
        chk("stall_push_a", got_result, 32'd1);
        ci(8'd0, 2'd0, 32'hBBBB_BBBB);
        ci(8'd0, 2'd0, 32'hCCCC_CCCC);
        ci(8'd0, 2'd0, 32'hDDDD_DDDD);
        chk("stall_push_d", got_result, 32'd1);
        ci(8'd0, 2'd2, 32'd0);
        chk("stall_status", got_result, 32'h0000_0248);
        ci(8'd0, 2'd0, 32'hEEEE_EEEE);
        chk("full_push_done", {31'd0, got_done}, 32'd1);
        chk("full_push_drop", got_result, 32'd0);
        ci(8'd0, 2'd1, 32'd0);
        chk("stall_pop", got_result, 32'h8000_0400);
        idle(2);
        ci(8'd0, 2'd2, 32'd0);
        chk("refill_status", got_result, 32'h0000_0248);
        ci(8'd0, 2'd1, 32'd0);
        chk("stall_pop2", got_result, 32'h8410_8400);
        ci(8'd0, 2'd3, 32'd0);
        chk("clear2", got_result, 32'd0);

        // CLEAR at beat 2 of a conversion.
        ci(8'd0, 2'd0, 32'h0000_4321);
        idle(3);
        ci(8'd0, 2'd3, 32'd0);
        chk("midconv_clear_done", {31'd0, got_done}, 32'd1);
        chk("midconv_clear", got_result, 32'd0);
        ci(8'd0, 2'd2, 32'd0);
        chk("post_clear_status", got_result, 32'h0000_0000);
        ci(8'd0, 2'd1, 32'd0);
        chk("post_clear_pop_done", {31'd0, got_done}, 32'd1);
        chk("post_clear_pop", got_result, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
